// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_receiver
//  Purpose  : 8N1 asynchronous serial receiver, LSB first. The line is
//             synchronised, a falling edge starts a frame, the start bit is
//             re-checked at mid-bit, and data/stop bits are sampled at their
//             centres. Good frames update data_receive together with a
//             one-cycle receive_done pulse; a low stop bit gives a one-cycle
//             frame_err pulse and leaves data_receive untouched.
//  Ports    : clk          - system clock, rising edge
//             rst_n        - asynchronous active-low reset
//             uart_rxd     - serial input line, idle high
//             receive_done - one-cycle pulse, valid frame received
//             data_receive - last valid received byte
//             frame_err    - one-cycle pulse, stop bit sampled low
//             busy         - high whenever the FSM is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int SYS_PERIOD = 50_000_000,
    parameter int BPS        = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic       receive_done,
    output logic [7:0] data_receive,
    output logic       frame_err,
    output logic       busy
);

    localparam int c_HALF_BIT_PERIOD = SYS_PERIOD / BPS / 2;
    localparam int c_BIT_PERIOD      = 2 * c_HALF_BIT_PERIOD;

    localparam logic [14:0] c_HALF_LAST = 15'(c_HALF_BIT_PERIOD - 1);
    localparam logic [14:0] c_BIT_LAST  = 15'(c_BIT_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and edge detector. All three flops reset high so
    // that releasing reset with an idle line cannot look like a start edge.
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic r_rxd_d;
    logic w_rxd_s;
    logic w_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rxd_d <= 1'b1;
        end else begin
            r_sync1 <= uart_rxd;
            r_sync2 <= r_sync1;
            r_rxd_d <= r_sync2;
        end
    end

    assign w_rxd_s = r_sync2;
    assign w_fall  = r_rxd_d & ~w_rxd_s;

    // ------------------------------------------------------------------
    // Receive FSM with registered outputs
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [14:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_done;
    logic        r_err;
    logic        r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 15'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses unless set below
            r_done <= 1'b0;
            r_err  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cnt     <= 15'd0;
                    r_bit_idx <= 3'd0;
                    if (w_fall) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt <= 15'd0;
                        if (!w_rxd_s) begin
                            r_state <= S_DATA;
                        end else begin
                            // Line went high again before mid start bit:
                            // treat as a glitch and quietly give up.
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 15'd1;
                    end
                end

                S_DATA: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt   <= 15'd0;
                        // LSB arrives first, so shift in from the top
                        r_shift <= {w_rxd_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
                            r_state   <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 15'd1;
                    end
                end

                S_STOP: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt   <= 15'd0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (w_rxd_s) begin
                            // Output byte only changes here, in the same
                            // cycle as the done pulse, so a downstream
                            // consumer can capture it on receive_done.
                            r_data <= r_shift;
                            r_done <= 1'b1;
                        end else begin
                            r_err  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 15'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 15'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign receive_done = r_done;
    assign frame_err    = r_err;
    assign data_receive = r_data;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_receiver
//  Purpose  : Directed self-checking bench for uart_receiver at the default
//             50 MHz / 115200 bit/s setting (434 clocks per bit).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int c_BIT = 434;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       receive_done;
    logic [7:0] data_receive;
    logic       frame_err;
    logic       busy;

    uart_receiver #(
        .SYS_PERIOD (50_000_000),
        .BPS        (115_200)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_rxd     (uart_rxd),
        .receive_done (receive_done),
        .data_receive (data_receive),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_fall   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int         done_time[$];
    logic [7:0] done_data[$];

    always @(posedge clk) cyc++;

    // Pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (receive_done) begin
            done_cnt++;
            done_time.push_back(cyc);
            done_data.push_back(data_receive);
        end
        if (frame_err) err_cnt++;
        if (receive_done && frame_err) both_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One 8N1 frame. The stop bit is held 433 cycles so that a following
    // call (which waits one more edge) produces a gapless 434-cycle stop.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge clk); #1;
        uart_rxd = 1'b0;
        t_fall   = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (c_BIT) @(posedge clk);
            #1 uart_rxd = b[i];
        end
        repeat (c_BIT) @(posedge clk);
        #1 uart_rxd = stop_bit;
        repeat (c_BIT - 1) @(posedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int gap;
        logic [7:0] b;
        logic [9:0] tx_frame;

        // ---------------- reset state ----------------
        repeat (5) @(posedge clk);
        #1;
        check_val("rst_data", {24'd0, data_receive}, 32'h00);
        check_val("rst_done", {31'd0, receive_done}, 32'd0);
        check_val("rst_err",  {31'd0, frame_err},    32'd0);
        check_val("rst_busy", {31'd0, busy},         32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 check_val("idle_busy", {31'd0, busy}, 32'd0);

        // ---------------- single byte 0x55 ----------------
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (1000) @(posedge clk);
                #1 check_val("busy_mid", {31'd0, busy}, 32'd1);
            end
        join
        repeat (20) @(posedge clk);
        #1;
        check_val("55_count", done_cnt, 32'd1);
        check_val("55_data",  {24'd0, data_receive}, 32'h55);
        check_val("55_err",   err_cnt, 32'd0);
        lat = (done_time.size() > 0) ? done_time[0] - t_fall : 0;
        check_val("55_latency_ok", {31'd0, (lat >= 4124 && lat <= 4128)}, 32'd1);
        check_val("55_busy_end", {31'd0, busy}, 32'd0);

        // ---------------- back-to-back 0xA3, 0x0F ----------------
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check_val("b2b_count", done_cnt, 32'd3);
        check_val("b2b_first",  {24'd0, done_data[1]}, 32'hA3);
        check_val("b2b_second", {24'd0, done_data[2]}, 32'h0F);
        gap = (done_time.size() > 2) ? done_time[2] - done_time[1] : 0;
        check_val("b2b_gap_ok", {31'd0, (gap >= 4338 && gap <= 4342)}, 32'd1);
        check_val("b2b_data", {24'd0, data_receive}, 32'h0F);

        // ---------------- 100-clock glitch ----------------
        @(posedge clk); #1 uart_rxd = 1'b0;
        repeat (100) @(posedge clk);
        #1 uart_rxd = 1'b1;
        repeat (50) @(posedge clk);
        #1 check_val("glitch_busy_start", {31'd0, busy}, 32'd1);
        repeat (400) @(posedge clk);
        #1;
        check_val("glitch_busy_end", {31'd0, busy}, 32'd0);
        check_val("glitch_done", done_cnt, 32'd3);
        check_val("glitch_err",  err_cnt,  32'd0);
        check_val("glitch_data", {24'd0, data_receive}, 32'h0F);

        // ---------------- framing error then break ----------------
        send_frame(8'h3C, 1'b0);
        check_val("ferr_count", err_cnt, 32'd1);
        repeat (20 * c_BIT) @(posedge clk);
        #1;
        check_val("break_err",  err_cnt,  32'd1);
        check_val("break_done", done_cnt, 32'd3);
        check_val("break_data", {24'd0, data_receive}, 32'h0F);
        check_val("break_busy", {31'd0, busy}, 32'd0);
        uart_rxd = 1'b1;
        repeat (1000) @(posedge clk);
        #1 check_val("after_break_err", err_cnt, 32'd1);

        // ---------------- reset during bit 4 ----------------
        b = 8'h5A;
        @(posedge clk); #1 uart_rxd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (c_BIT) @(posedge clk);
            #1 uart_rxd = b[i];
        end
        repeat (200) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_val("midrst_data", {24'd0, data_receive}, 32'h00);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_done", {31'd0, receive_done}, 32'd0);
        check_val("midrst_err",  {31'd0, frame_err}, 32'd0);
        uart_rxd = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (10 * c_BIT) @(posedge clk);
        #1;
        check_val("abort_done", done_cnt, 32'd3);
        check_val("abort_err",  err_cnt,  32'd1);
        send_frame(8'h81, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check_val("81_count", done_cnt, 32'd4);
        check_val("81_data",  {24'd0, data_receive}, 32'h81);

        // ---------------- loopback 0xC7 ----------------
        send_frame(8'hC7, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check_val("c7_count", done_cnt, 32'd5);
        // Frame a transmitter would emit from the captured byte: stop,data,start
        tx_frame = {1'b1, done_data[done_data.size() - 1], 1'b0};
        check_val("c7_loop_frame", {22'd0, tx_frame}, 32'h38E);

        check_val("done_err_exclusive", both_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter SYS_PERIOD, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BPS, default 115_200, line rate in bit/s.
REQ-003 SHALL derive HALF_BIT_PERIOD = SYS_PERIOD/BPS/2 (217 at defaults) and BIT_PERIOD = 2*HALF_BIT_PERIOD (434).
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port uart_rxd  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-007 SHALL have port receive_done  output  1  one-cycle pulse: valid frame received.
REQ-008 SHALL have port data_receive  output  8  last valid received byte.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL pass uart_rxd through a 2-flop synchronizer; all decisions use the synchronized value rxd_s.
REQ-012 SHALL detect a falling edge as rxd_s delayed-by-one == 1 and rxd_s == 0.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-014 SHALL use a 15-bit cycle counter cnt, cleared on every state transition and when each bit is sampled.
REQ-015 SHALL move IDLE -> START on a detected falling edge; all other IDLE cycles stay in IDLE.
REQ-016 SHALL in START sample rxd_s at cnt == HALF_BIT_PERIOD-1; 0 -> DATA, 1 -> IDLE (glitch rejected, no pulse output).
REQ-017 SHALL in DATA sample rxd_s at cnt == BIT_PERIOD-1 eight times, shifting into bit 7 of a shift register (LSB arrives first), with a 3-bit bit index.
REQ-018 SHALL move DATA -> STOP after the 8th sample (bit index 7 sampled).
REQ-019 SHALL in STOP sample rxd_s at cnt == BIT_PERIOD-1, then go to IDLE.
REQ-020 SHALL, on stop sample 1, load data_receive from the shift register and pulse receive_done for exactly one cycle, in the same cycle as the update.
REQ-021 SHALL, on stop sample 0, pulse frame_err for one cycle and leave data_receive unchanged.
REQ-022 SHALL hold data_receive stable between valid frames, because the downstream transmitter captures it in the receive_done cycle.
REQ-023 SHALL ignore falling edges outside IDLE.
REQ-024 SHALL accept a start edge in the first IDLE cycle after STOP, so back-to-back frames are received.
REQ-025 SHALL NOT restart after a framing error while the line stays low (break); the next frame needs a new falling edge.
REQ-026 SHALL never assert receive_done and frame_err in the same cycle.
REQ-027 SHALL sample each data bit HALF_BIT_PERIOD + k*BIT_PERIOD cycles (k=1..8) after START entry, and the stop bit at +9*BIT_PERIOD (4123 at defaults).

Reset
REQ-028 SHALL on rst_n low immediately force: state IDLE, cnt 0, bit index 0, shift register 0x00, data_receive 0x00, receive_done 0, frame_err 0, busy 0.
REQ-029 SHALL reset both synchronizer flops and the edge-detect flop to 1, so releasing reset never creates a false start edge.
REQ-030 SHALL, on reset mid-frame, abandon the frame without emitting receive_done or frame_err.

Verification
REQ-031 Send 0x55 at 115200 (434 clk/bit) -> one receive_done pulse, data_receive = 0x55, frame_err stays 0, pulse 4126±2 clk after the uart_rxd falling edge.
REQ-032 Send 0xA3 immediately followed by 0x0F, with no idle gap -> two receive_done pulses, one BIT_PERIOD*10 ±2 clk apart, with data_receive 0xA3 then 0x0F.
REQ-033 Drive a 100-clk low glitch on idle line -> FSM returns to IDLE at START sample, no receive_done/frame_err, data_receive unchanged.
REQ-034 Send 0x3C with stop bit forced 0 -> one frame_err pulse, no receive_done, data_receive holds previous value; line held low 20 bit times -> no further pulses.
REQ-035 Assert rst_n low during bit 4 of a frame, release, then send 0x81 -> no pulse from aborted frame; outputs zero during reset; 0x81 then received correctly.
REQ-036 Connect to uart_transmitter loopback, send 0xC7 -> transmitter emits identical 0xC7 frame on uart_txd.
